// File: rtl/wavetable_interp.sv
// Crossfaded linear interpolator between two waveform tables (interpolating and anti-alias).
// Fixed-latency pipeline: ROM_LAT-deep alignment delay, then five registered arithmetic stages.
module wavetable_interp #(
    parameter int DWIDTH  = 16,
    parameter int FWIDTH  = 8,
    parameter int ROM_LAT = 2
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     req,
    input  logic [FWIDTH-1:0]        frac,
    input  logic [FWIDTH:0]          xfade,
    input  logic signed [DWIDTH-1:0] interp_a,
    input  logic signed [DWIDTH-1:0] interp_b,
    input  logic signed [DWIDTH-1:0] anti_a,
    input  logic signed [DWIDTH-1:0] anti_b,
    output logic                     out_valid,
    output logic signed [DWIDTH-1:0] sample_out
);

    localparam int DW1 = DWIDTH + 1;
    localparam int PW  = DWIDTH + FWIDTH + 2;
    localparam logic [FWIDTH:0] XF_FULL = {1'b1, {FWIDTH{1'b0}}};

    // Alignment delay line for the request and its control fields
    logic [ROM_LAT-1:0] dl_req;
    logic [FWIDTH-1:0]  dl_frac  [ROM_LAT];
    logic [FWIDTH:0]    dl_xfade [ROM_LAT];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            // NOTE: every register here is cleared, including the delay-line arrays, so no stale
            // request or data can leak out after reset.
            for (int i = 0; i < ROM_LAT; i++) begin
                dl_req[i]   <= 1'b0;
                dl_frac[i]  <= '0;
                dl_xfade[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let each tap take its predecessor's old value.
            dl_req[0]   <= req;
            dl_frac[0]  <= frac;
            dl_xfade[0] <= xfade;
            for (int i = 1; i < ROM_LAT; i++) begin
                dl_req[i]   <= dl_req[i-1];
                dl_frac[i]  <= dl_frac[i-1];
                dl_xfade[i] <= dl_xfade[i-1];
            end
        end
    end

    logic                     s1_v;
    logic signed [DWIDTH-1:0] s1_ia, s1_aa;
    logic signed [DW1-1:0]    s1_id, s1_ad;
    logic [FWIDTH-1:0]        s1_frac;
    logic [FWIDTH:0]          s1_xf;

    logic                     s2_v;
    logic signed [DWIDTH-1:0] s2_ia, s2_aa;
    logic signed [PW-1:0]     s2_ip, s2_ap;
    logic [FWIDTH:0]          s2_xf;

    logic                     s3_v;
    logic signed [DWIDTH-1:0] s3_iy, s3_ay;
    logic [FWIDTH:0]          s3_xf;

    logic                     s4_v;
    logic signed [DWIDTH-1:0] s4_ay;
    logic signed [PW-1:0]     s4_q;

    logic signed [PW-1:0]     ip_c, ap_c, iy_c, ay_c, q_c, out_c;
    logic signed [DW1-1:0]    diff_c;
    logic [FWIDTH:0]          xf_c;

    // frac and xf are unsigned weights; a zero MSB keeps them non-negative in signed products
    assign ip_c   = PW'(s1_id) * PW'($signed({1'b0, s1_frac}));
    assign ap_c   = PW'(s1_ad) * PW'($signed({1'b0, s1_frac}));
    assign iy_c   = PW'(s2_ia) + (s2_ip >>> FWIDTH);
    assign ay_c   = PW'(s2_aa) + (s2_ap >>> FWIDTH);
    assign xf_c   = (s3_xf > XF_FULL) ? XF_FULL : s3_xf;
    assign diff_c = DW1'(s3_iy) - DW1'(s3_ay);
    assign q_c    = PW'(diff_c) * PW'($signed({1'b0, xf_c}));
    assign out_c  = PW'(s4_ay) + (s4_q >>> FWIDTH);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_v <= 1'b0; s1_ia <= '0; s1_aa <= '0; s1_id <= '0; s1_ad <= '0;
            s1_frac <= '0; s1_xf <= '0;
            s2_v <= 1'b0; s2_ia <= '0; s2_aa <= '0; s2_ip <= '0; s2_ap <= '0; s2_xf <= '0;
            s3_v <= 1'b0; s3_iy <= '0; s3_ay <= '0; s3_xf <= '0;
            s4_v <= 1'b0; s4_ay <= '0; s4_q <= '0;
            out_valid  <= 1'b0;
            sample_out <= '0;
        end else begin
            s1_v      <= dl_req[ROM_LAT-1];
            s2_v      <= s1_v;
            s3_v      <= s2_v;
            s4_v      <= s3_v;
            out_valid <= s4_v;

            // Data registers load only with a valid token, so idle cycles leave results untouched
            if (dl_req[ROM_LAT-1]) begin
                s1_ia   <= interp_a;
                s1_aa   <= anti_a;
                s1_id   <= DW1'(interp_b) - DW1'(interp_a);
                s1_ad   <= DW1'(anti_b) - DW1'(anti_a);
                s1_frac <= dl_frac[ROM_LAT-1];
                s1_xf   <= dl_xfade[ROM_LAT-1];
            end
            if (s1_v) begin
                s2_ia <= s1_ia;
                s2_aa <= s1_aa;
                s2_ip <= ip_c;
                s2_ap <= ap_c;
                s2_xf <= s1_xf;
            end
            if (s2_v) begin
                s3_iy <= iy_c[DWIDTH-1:0];
                s3_ay <= ay_c[DWIDTH-1:0];
                s3_xf <= s2_xf;
            end
            if (s3_v) begin
                s4_ay <= s3_ay;
                s4_q  <= q_c;
            end
            if (s4_v) begin
                sample_out <= out_c[DWIDTH-1:0];
            end
        end
    end

endmodule
